// File: rtl/axi_burst_reader.sv
// axi_burst_reader: AXI4 read master that fetches a contiguous block of
// AXI_WIDTH-bit words and streams them out on AXI-Stream.
//
// A command (byte address, beat count) is split into INCR bursts no longer
// than AXI_MAX_BURST_LEN that never cross a 4 KB boundary. Only one burst
// is outstanding at a time. R data passes combinationally to the stream
// port, so the stream's backpressure goes straight back to rready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_*               command handshake, start byte address, beat count
//   m_axi_ar*           AXI4 read address channel (ARID fixed at 0)
//   m_axi_r*            AXI4 read data channel (RID ignored)
//   m_axis_*            output stream; tlast marks the last beat of a command
//   busy                high while a command is in progress
//   err                 sticky error (bad RRESP or RLAST mismatch), cleared
//                       when the next command is accepted
module axi_burst_reader #(
  parameter int AXI_WIDTH         = 128,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 6,
  parameter int AXI_MAX_BURST_LEN = 32,
  parameter int LEN_WIDTH         = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_beats,
  output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [AXI_WIDTH-1:0]      m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [AXI_WIDTH-1:0]      m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      busy,
  output logic                      err
);

  localparam int LSB = $clog2(AXI_WIDTH) - 3;
  // Common width for the burst-length minimum; wide enough for the 4 KB
  // distance (up to 4096) and for the full remaining count.
  localparam int CW  = (LEN_WIDTH > 14) ? LEN_WIDTH : 14;

  typedef enum logic [1:0] {IDLE, CALC, ADDR, DATA} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]      rem_q, rem_d;
  logic [8:0]                blen_q, blen_d;  // up to 256
  logic [8:0]                cnt_q, cnt_d;    // beats left in current burst
  logic [7:0]                arlen_q, arlen_d;
  logic                      err_q, err_d;

  logic [CW-1:0] rem_w, b4k_w, max_w, min_w;
  logic          beat;
  logic          last_of_burst;

  logic unused_rid;
  assign unused_rid = ^m_axi_rid;

  // blen = min(remaining, max burst, beats left before the 4 KB boundary)
  always_comb begin
    rem_w = CW'(rem_q);
    b4k_w = CW'((13'd4096 - {1'b0, addr_q[11:0]}) >> LSB);
    max_w = CW'(AXI_MAX_BURST_LEN);
    min_w = (rem_w < max_w) ? rem_w : max_w;
    if (b4k_w < min_w) min_w = b4k_w;
  end

  assign beat          = m_axi_rvalid && m_axis_tready && (state_q == DATA);
  assign last_of_burst = (cnt_q == 9'd1);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    blen_d   = blen_q;
    cnt_d    = cnt_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = {cmd_addr[AXI_ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
          rem_d  = cmd_beats;
          err_d  = 1'b0;
          // A zero-length command is accepted but does nothing.
          if (cmd_beats != '0) state_d = CALC;
        end
      end
      CALC: begin
        blen_d   = min_w[8:0];
        araddr_d = addr_q;
        arlen_d  = min_w[7:0] - 8'd1;
        state_d  = ADDR;
      end
      ADDR: begin
        if (m_axi_arready) begin
          cnt_d   = blen_q;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          cnt_d = cnt_q - 9'd1;
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          // The local beat count decides burst end; RLAST is only checked.
          if (m_axi_rlast != last_of_burst) err_d = 1'b1;
          if (last_of_burst) begin
            addr_d  = addr_q + (AXI_ADDR_WIDTH'(blen_q) << LSB);
            rem_d   = rem_q - LEN_WIDTH'(blen_q);
            state_d = (rem_q == LEN_WIDTH'(blen_q)) ? IDLE : CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      araddr_q <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      cnt_q    <= '0;
      arlen_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      araddr_q <= araddr_d;
      rem_q    <= rem_d;
      blen_q   <= blen_d;
      cnt_q    <= cnt_d;
      arlen_q  <= arlen_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(LSB);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state_q == ADDR);

  assign m_axi_rready  = m_axis_tready && (state_q == DATA);
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tvalid = m_axi_rvalid && (state_q == DATA);
  // Final beat of the command: last beat of a burst that covers the rest.
  assign m_axis_tlast  = (state_q == DATA) && last_of_burst &&
                         (rem_q == LEN_WIDTH'(blen_q));

endmodule

// File: doc/axi_burst_reader.md
Name: axi_burst_reader

Overview:
- AXI4 full read master: a DMA-style reader that fetches a contiguous block of words from memory.
- Accepts one command (byte address, beat count), splits it into INCR bursts and streams the returned data out on an AXI-Stream port.
- Pairs with the AXI-to-RAM slave used in simulation; it is the initiator end of the same AXI4 read channel.
- Sits between the DDR/AXI port and the array input buffers.

Parameters:
- AXI_WIDTH, 128, AXI data width in bits; power of two, at least 32.
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_ID_WIDTH, 6, ARID width; ARID is constant 0.
- AXI_MAX_BURST_LEN, 32, maximum beats per burst; range 1..256.
- LEN_WIDTH, 20, width of the command beat count.
- LSB (localparam), $clog2(AXI_WIDTH)-3, byte-offset bits per beat.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address; low LSB bits are ignored (treated as 0).
- cmd_beats  in  LEN_WIDTH  number of AXI_WIDTH beats to read.
- m_axi_arid  out  AXI_ID_WIDTH  constant 0.
- m_axi_araddr  out  AXI_ADDR_WIDTH  burst start address.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  constant LSB.
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arlock  out  1  constant 0.
- m_axi_arcache  out  4  constant 4'b0011.
- m_axi_arprot  out  3  constant 0.
- m_axi_arvalid / m_axi_arready  out/in  1  address handshake.
- m_axi_rid  in  AXI_ID_WIDTH  ignored.
- m_axi_rdata  in  AXI_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat of burst.
- m_axi_rvalid / m_axi_rready  in/out  1  data handshake.
- m_axis_tdata  out  AXI_WIDTH  stream data.
- m_axis_tvalid / m_axis_tready  out/in  1  stream handshake.
- m_axis_tlast  out  1  final beat of the whole command.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  sticky error flag; cleared on the next command accept.

Behaviour:
- Reset (async, rst=1): state=IDLE; cmd_ready=1; arvalid=0; rready=0; busy=0; err=0; all address/length registers 0. Reset overrides any in-flight handshake; the bench must reset the slave together with this block.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch addr (low LSB bits zeroed) and remaining=cmd_beats; clear err.
    - If cmd_beats==0, stay in IDLE. No AR is issued, no stream beat is produced, cmd_ready stays 1.
    - Otherwise go to CALC. cmd_ready=0 in all other states.
  - CALC (1 cycle): compute the burst length.
    - blen = min(remaining, AXI_MAX_BURST_LEN, beats_to_4KB).
    - beats_to_4KB = (4096 - addr[11:0]) >> LSB.
    - Register araddr=addr and arlen=blen-1, then go to ADDR.
  - ADDR: arvalid=1. araddr/arlen are held stable until arready. On handshake: arvalid=0, load the beat counter with blen, go to DATA.
  - DATA: each R handshake passes one beat to the stream and decrements the beat counter.
    - After the last beat of the burst: addr += blen<<LSB; remaining -= blen.
    - Go to CALC if remaining>0, else IDLE.
- Only one burst is outstanding at a time; the next AR is issued only after the previous burst's final R beat.
- Data path is combinational pass-through, zero latency:
  - tdata = rdata.
  - tvalid = rvalid && state==DATA.
  - rready = tready && state==DATA.
  - A beat transfers when rvalid && tready.
- tlast = (state==DATA) && beat counter==1 && remaining==blen.
- Error conditions; in every case the block completes the expected beat count and returns to IDLE:
  - rresp != 2'b00 on any beat: err=1 and the beat is still forwarded.
  - rlast high when the beat counter != 1, or rlast low when the beat counter == 1: err=1. The beat count is trusted over rlast.
- Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH. No burst crosses a 4 KB boundary.
- A cmd_valid asserted while busy is not accepted; the command must be held until cmd_ready.
- busy = (state != IDLE).

Test Plan:
- AXI_WIDTH=128, cmd addr 0x1000, beats 4, ready always high → one AR with araddr 0x1000, arlen 3, arsize 4. Four stream beats match memory; tlast only on beat 4; busy drops 1 cycle after the last beat.
- cmd addr 0x0, beats 70, MAX=32 → ARs at 0x000 (len 31), 0x200 (len 31), 0x400 (len 5). 70 beats in order; a single tlast at the end.
- cmd addr 0x0FC0, beats 8 → AR 0x0FC0 len 3, then AR 0x1000 len 3. No burst crosses 4 KB.
- Random arready/rvalid/tready at 50% each, beats 100 → data sequence and count identical to the no-stall case. araddr/arlen stay stable while arvalid && !arready; no beat is lost or duplicated.
- beats 0 → no arvalid, no tvalid, cmd_ready stays 1. Slave returns rresp=2'b10 on beat 2 of a 4-beat read → err=1 after that beat, all 4 beats forwarded, err cleared at the next command accept.
- rst asserted mid-DATA of a 32-beat burst → arvalid, rready, tvalid, busy and err drop immediately. After release, a new 4-beat command completes correctly.
